fpu_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the single multi-cycle FPU core.
- Accepts operand/opcode/rounding requests from two clients and issues them one at a time as a one-cycle `fpu_start`.
- Waits for the FPU completion strobe, then returns Y/Error/Overflow to the originating client.
- A watchdog converts a hung FPU operation into an Error response so clients never deadlock.

---
 rtl/fpu_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fpu_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_arbiter.sv
// Two-client round-robin front end for the shared multi-cycle FPU core.
// Issues one operation at a time, returns the result to its owner, and times out hung operations.
module fpu_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        req0,
    input  logic [31:0] A0,
    input  logic [31:0] B0,
    input  logic [1:0]  Sel0,
    input  logic [1:0]  round0,
    input  logic        req1,
    input  logic [31:0] A1,
    input  logic [31:0] B1,
    input  logic [1:0]  Sel1,
    input  logic [1:0]  round1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rsp_valid0,
    output logic        rsp_valid1,
    output logic [31:0] rsp_Y,
    output logic        rsp_Error,
    output logic        rsp_Overflow,
    output logic        busy,
    output logic        fpu_start,
    output logic [31:0] fpu_A,
    output logic [31:0] fpu_B,
    output logic [1:0]  fpu_Sel,
    output logic [1:0]  fpu_round,
    input  logic [31:0] fpu_Y,
    input  logic        fpu_Error,
    input  logic        fpu_Overflow,
    input  logic        fpu_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT - 1);

    state_t        state, state_n;
    logic          owner, owner_n;
    logic          last, last_n;
    logic [CW-1:0] wd, wd_n;
    logic          pick0, pick1;

    logic          gnt0_n, gnt1_n, rsp_valid0_n, rsp_valid1_n, busy_n, fpu_start_n;
    logic [31:0]   rsp_Y_n, fpu_A_n, fpu_B_n;
    logic          rsp_Error_n, rsp_Overflow_n;
    logic [1:0]    fpu_Sel_n, fpu_round_n;

    always_comb begin
        state_n        = state;
        owner_n        = owner;
        last_n         = last;
        wd_n           = wd;
        gnt0_n         = 1'b0;
        gnt1_n         = 1'b0;
        rsp_valid0_n   = 1'b0;
        rsp_valid1_n   = 1'b0;
        fpu_start_n    = 1'b0;
        fpu_A_n        = fpu_A;
        fpu_B_n        = fpu_B;
        fpu_Sel_n      = fpu_Sel;
        fpu_round_n    = fpu_round;
        rsp_Y_n        = rsp_Y;
        rsp_Error_n    = rsp_Error;
        rsp_Overflow_n = rsp_Overflow;
        // On a tie the client that was not served last wins.
        pick0 = req0 && (!req1 || last);
        pick1 = req1 && (!req0 || !last);

        case (state)
            IDLE: begin
                if (pick0 || pick1) begin
                    owner_n     = pick1;
                    last_n      = pick1;
                    fpu_A_n     = pick1 ? A1 : A0;
                    fpu_B_n     = pick1 ? B1 : B0;
                    fpu_Sel_n   = pick1 ? Sel1 : Sel0;
                    fpu_round_n = pick1 ? round1 : round0;
                    gnt0_n      = pick0;
                    gnt1_n      = pick1;
                    fpu_start_n = 1'b1;
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                wd_n    = '0;
                state_n = WAIT;
            end
            WAIT: begin
                // A completion on the watchdog's last cycle still returns the real result.
                if (fpu_done) begin
                    rsp_Y_n        = fpu_Y;
                    rsp_Error_n    = fpu_Error;
                    rsp_Overflow_n = fpu_Overflow;
                    rsp_valid0_n   = !owner;
                    rsp_valid1_n   = owner;
                    state_n        = RESP;
                end else if (wd == WD_LIMIT) begin
                    rsp_Y_n        = '0;
                    rsp_Error_n    = 1'b1;
                    rsp_Overflow_n = 1'b0;
                    rsp_valid0_n   = !owner;
                    rsp_valid1_n   = owner;
                    state_n        = RESP;
                end else begin
                    wd_n = wd + CW'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last         <= 1'b1;
            wd           <= '0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            rsp_valid0   <= 1'b0;
            rsp_valid1   <= 1'b0;
            busy         <= 1'b0;
            fpu_start    <= 1'b0;
            fpu_A        <= '0;
            fpu_B        <= '0;
            fpu_Sel      <= '0;
            fpu_round    <= '0;
            rsp_Y        <= '0;
            rsp_Error    <= 1'b0;
            rsp_Overflow <= 1'b0;
        end else begin
            state        <= state_n;
            owner        <= owner_n;
            last         <= last_n;
            wd           <= wd_n;
            gnt0         <= gnt0_n;
            gnt1         <= gnt1_n;
            rsp_valid0   <= rsp_valid0_n;
            rsp_valid1   <= rsp_valid1_n;
            busy         <= busy_n;
            fpu_start    <= fpu_start_n;
            fpu_A        <= fpu_A_n;
            fpu_B        <= fpu_B_n;
            fpu_Sel      <= fpu_Sel_n;
            fpu_round    <= fpu_round_n;
            rsp_Y        <= rsp_Y_n;
            rsp_Error    <= rsp_Error_n;
            rsp_Overflow <= rsp_Overflow_n;
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter: stimulus queues expected issues/responses, monitors compare.
// A behavioural FPU model answers each start after a per-operation latency (0 = never).
module tb_fpu_arbiter;

    localparam int TO = 16;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        req0, req1;
    logic [31:0] A0, B0, A1, B1;
    logic [1:0]  Sel0, round0, Sel1, round1;
    logic        gnt0, gnt1, rsp_valid0, rsp_valid1;
    logic [31:0] rsp_Y;
    logic        rsp_Error, rsp_Overflow, busy, fpu_start;
    logic [31:0] fpu_A, fpu_B;
    logic [1:0]  fpu_Sel, fpu_round;
    logic [31:0] fpu_Y;
    logic        fpu_Error, fpu_Overflow, fpu_done;
    logic        model_done, stray_done;

    assign fpu_done = model_done | stray_done;

    fpu_arbiter #(.TIMEOUT(TO), .CW(16)) dut (
        .Clock(Clock), .Reset(Reset),
        .req0(req0), .A0(A0), .B0(B0), .Sel0(Sel0), .round0(round0),
        .req1(req1), .A1(A1), .B1(B1), .Sel1(Sel1), .round1(round1),
        .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_Y(rsp_Y), .rsp_Error(rsp_Error), .rsp_Overflow(rsp_Overflow), .busy(busy),
        .fpu_start(fpu_start), .fpu_A(fpu_A), .fpu_B(fpu_B), .fpu_Sel(fpu_Sel),
        .fpu_round(fpu_round), .fpu_Y(fpu_Y), .fpu_Error(fpu_Error),
        .fpu_Overflow(fpu_Overflow), .fpu_done(fpu_done)
    );

    always #5 Clock = ~Clock;

    typedef struct packed { logic c; logic [31:0] a; logic [31:0] b; logic [1:0] s; logic [1:0] r; } iss_t;
    typedef struct packed { logic [7:0] lat; logic [31:0] y; logic e; logic o; } fpu_t;
    typedef struct packed { logic c; logic [31:0] y; logic e; logic o; logic [7:0] lat; } rsp_t;

    iss_t iss_q[$];
    fpu_t fpu_q[$];
    rsp_t rsp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;
    bit outstanding = 1'b0;
    int cnt = 0;
    fpu_t cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // FPU model: pops one latency/result descriptor per fpu_start.
    always @(negedge Clock) begin
        model_done   = 1'b0;
        fpu_Y        = 32'hDEADBEEF;
        fpu_Error    = 1'b1;
        fpu_Overflow = 1'b1;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                model_done   = 1'b1;
                fpu_Y        = cur.y;
                fpu_Error    = cur.e;
                fpu_Overflow = cur.o;
            end
        end
        if (fpu_start && !Reset && fpu_q.size() > 0) begin
            cur = fpu_q.pop_front();
            cnt = (cur.lat >= 2) ? int'(cur.lat) - 1 : 0;
        end
    end

    // Monitor: checks each issue and each response against the scoreboard queues.
    always @(negedge Clock) begin
        iss_t ei;
        rsp_t er;
        cyc++;
        if (Reset) begin
            outstanding = 1'b0;
        end else begin
            if (fpu_start) begin
                check("start_overlap", 64'(outstanding), 64'(0));
                outstanding = 1'b1;
                start_cyc = cyc;
                if (iss_q.size() == 0) begin
                    check("unexpected_start", 64'(fpu_start), 64'(0));
                end else begin
                    ei = iss_q.pop_front();
                    check("gnt", 64'({gnt1, gnt0}), ei.c ? 64'(2) : 64'(1));
                    check("fpu_A", 64'(fpu_A), 64'(ei.a));
                    check("fpu_B", 64'(fpu_B), 64'(ei.b));
                    check("fpu_Sel_round", 64'({fpu_Sel, fpu_round}), 64'({ei.s, ei.r}));
                end
            end else if (gnt0 || gnt1) begin
                check("gnt_without_start", 64'({gnt1, gnt0}), 64'(0));
            end
            if (rsp_valid0 || rsp_valid1) begin
                outstanding = 1'b0;
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 64'({rsp_valid1, rsp_valid0}), 64'(0));
                end else begin
                    er = rsp_q.pop_front();
                    check("rsp_client", 64'({rsp_valid1, rsp_valid0}), er.c ? 64'(2) : 64'(1));
                    check("rsp_Y", 64'(rsp_Y), 64'(er.y));
                    check("rsp_Err_Ovf", 64'({rsp_Error, rsp_Overflow}), 64'({er.e, er.o}));
                    check("rsp_latency", 64'(cyc - start_cyc), 64'(er.lat));
                end
            end
        end
    end

    task automatic push_op(input logic c, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] s, input logic [1:0] r,
                           input int flat, input logic [31:0] fy, input logic fe, input logic fo,
                           input logic [31:0] ey, input logic ee, input logic eo,
                           input int elat, input bit want_rsp);
        iss_t i;
        fpu_t f;
        rsp_t p;
        i.c = c; i.a = a; i.b = b; i.s = s; i.r = r;
        f.lat = 8'(flat); f.y = fy; f.e = fe; f.o = fo;
        p.c = c; p.y = ey; p.e = ee; p.o = eo; p.lat = 8'(elat);
        iss_q.push_back(i);
        fpu_q.push_back(f);
        if (want_rsp) rsp_q.push_back(p);
    endtask

    // Holds each request until it has collected the wanted number of grants.
    task automatic run_grants(input int n0, input int n1);
        int g0 = 0;
        int g1 = 0;
        int guard = 0;
        @(negedge Clock);
        req0 = (n0 > 0);
        req1 = (n1 > 0);
        while ((g0 < n0 || g1 < n1) && guard < 600) begin
            @(negedge Clock);
            guard++;
            if (gnt0) begin g0++; if (g0 >= n0) req0 = 1'b0; end
            if (gnt1) begin g1++; if (g1 >= n1) req1 = 1'b0; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("grant_counts", 64'({16'(g0), 16'(g1)}), 64'({16'(n0), 16'(n1)}));
    endtask

    task automatic drain();
        int guard = 0;
        while ((rsp_q.size() != 0 || busy || cnt != 0) && guard < 300) begin
            @(negedge Clock);
            guard++;
        end
        check("drain_timeout", 64'(guard >= 300), 64'(0));
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_ctrl"}, 64'({gnt0, gnt1, rsp_valid0, rsp_valid1, busy, fpu_start}), 64'(0));
        check({tag, "_rsp"}, 64'({rsp_Y, rsp_Error, rsp_Overflow}), 64'(0));
        check({tag, "_fpuAB"}, {fpu_A, fpu_B}, 64'(0));
        check({tag, "_fpuSR"}, 64'({fpu_Sel, fpu_round}), 64'(0));
    endtask

    initial begin
        Reset = 1'b1; stray_done = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        A0 = '0; B0 = '0; Sel0 = '0; round0 = '0;
        A1 = '0; B1 = '0; Sel1 = '0; round1 = '0;
        repeat (3) @(negedge Clock);
        check_all_reset("reset");
        Reset = 1'b0;

        // Single client-0 add: 1.0 + 2.0 = 3.0, FPU answers 4 cycles after start.
        A0 = 32'h3F800000; B0 = 32'h40000000; Sel0 = 2'd0; round0 = 2'd0;
        push_op(1'b0, A0, B0, 2'd0, 2'd0, 4, 32'h40400000, 1'b0, 1'b0, 32'h40400000, 1'b0, 1'b0, 4, 1'b1);
        run_grants(1, 0);
        drain();

        // Overflow from client 1.
        A1 = 32'h7F000000; B1 = 32'h7F000000; Sel1 = 2'd2; round1 = 2'd1;
        push_op(1'b1, A1, B1, 2'd2, 2'd1, 3, 32'h7F800000, 1'b0, 1'b1, 32'h7F800000, 1'b0, 1'b1, 3, 1'b1);
        run_grants(0, 1);
        drain();

        // Both held: last served was client 1, so grants go 0,1,0,1,0,1.
        A0 = 32'h40800000; B0 = 32'h3F800000; Sel0 = 2'd1; round0 = 2'd1;
        A1 = 32'hC0000000; B1 = 32'h40400000; Sel1 = 2'd2; round1 = 2'd3;
        push_op(1'b0, A0, B0, 2'd1, 2'd1, 2, 32'h40A00000, 1'b0, 1'b0, 32'h40A00000, 1'b0, 1'b0, 2, 1'b1);
        push_op(1'b1, A1, B1, 2'd2, 2'd3, 3, 32'hC0A00000, 1'b0, 1'b0, 32'hC0A00000, 1'b0, 1'b0, 3, 1'b1);
        push_op(1'b0, A0, B0, 2'd1, 2'd1, 2, 32'h40400000, 1'b0, 1'b0, 32'h40400000, 1'b0, 1'b0, 2, 1'b1);
        push_op(1'b1, A1, B1, 2'd2, 2'd3, 5, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 5, 1'b1);
        push_op(1'b0, A0, B0, 2'd1, 2'd1, 2, 32'h40A00000, 1'b0, 1'b0, 32'h40A00000, 1'b0, 1'b0, 2, 1'b1);
        push_op(1'b1, A1, B1, 2'd2, 2'd3, 4, 32'hBF800000, 1'b0, 1'b0, 32'hBF800000, 1'b0, 1'b0, 4, 1'b1);
        run_grants(3, 3);
        drain();

        // Hung FPU: error response on the 16th WAIT edge, 17 cycles after start.
        A0 = 32'h3F000000; B0 = 32'h00000000; Sel0 = 2'd3; round0 = 2'd2;
        push_op(1'b0, A0, B0, 2'd3, 2'd2, 0, 32'h0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, TO + 1, 1'b1);
        run_grants(1, 0);
        drain();
        A1 = 32'h40000000; B1 = 32'h40000000; Sel1 = 2'd1; round1 = 2'd0;
        push_op(1'b1, A1, B1, 2'd1, 2'd0, 2, 32'h3F800000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 2, 1'b1);
        run_grants(0, 1);
        drain();

        // Stray completion strobe while idle must be ignored.
        @(negedge Clock); stray_done = 1'b1;
        @(negedge Clock); stray_done = 1'b0;
        repeat (3) @(negedge Clock);
        check("stray_busy", 64'(busy), 64'(0));
        check("rsp_hold_Y", 64'(rsp_Y), 64'(32'h3F800000));

        // Completion exactly at the watchdog limit returns the real result.
        A0 = 32'h41000000; B0 = 32'h40000000; Sel0 = 2'd0; round0 = 2'd3;
        push_op(1'b0, A0, B0, 2'd0, 2'd3, TO + 1, 32'h41200000, 1'b0, 1'b0, 32'h41200000, 1'b0, 1'b0, TO + 1, 1'b1);
        run_grants(1, 0);
        drain();

        // Reset one cycle into WAIT; the late completion must not produce a response.
        A1 = 32'h12345678; B1 = 32'h9ABCDEF0; Sel1 = 2'd3; round1 = 2'd3;
        push_op(1'b1, A1, B1, 2'd3, 2'd3, 5, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        run_grants(0, 1);
        @(negedge Clock); Reset = 1'b1;
        @(negedge Clock);
        check_all_reset("midreset");
        @(negedge Clock); Reset = 1'b0;
        repeat (8) @(negedge Clock);
        check_all_reset("after_late_done");

        // Tie right after reset goes to client 0, then client 1.
        A0 = 32'h3F800000; B0 = 32'h3F800000; Sel0 = 2'd0; round0 = 2'd0;
        A1 = 32'hBF800000; B1 = 32'h3F800000; Sel1 = 2'd1; round1 = 2'd1;
        push_op(1'b0, A0, B0, 2'd0, 2'd0, 2, 32'h40000000, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 2, 1'b1);
        push_op(1'b1, A1, B1, 2'd1, 2'd1, 3, 32'hBF800000, 1'b0, 1'b0, 32'hBF800000, 1'b0, 1'b0, 3, 1'b1);
        run_grants(1, 1);
        drain();

        check("iss_q_left", 64'(iss_q.size()), 64'(0));
        check("fpu_q_left", 64'(fpu_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "global timeout");
    end

endmodule
